// File: rtl/qmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qmem_arb_pkg
//  Purpose  : Shared constants and elaboration helpers for the QMEM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package qmem_arb_pkg;

  // Priority scheme selectors for the RR parameter
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Ceiling log2, evaluated at elaboration time
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Width of a master index; a single master still needs one bit
  function automatic int midw(input int mn);
    return (mn > 1) ? clog2(mn) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qmem_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : qmem_rr_picker
//  Purpose  : Combinational one-hot picker. Chooses the first set request at
//             or after i_ptr (wrapping), or the lowest index when i_rr is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module qmem_rr_picker
  import qmem_arb_pkg::*;
#(
  parameter int MN   = 4,
  parameter int MIDW = midw(MN)
) (
  input  logic [MN-1:0]   i_req,
  input  logic [MIDW-1:0] i_ptr,
  input  logic            i_rr,
  output logic [MN-1:0]   o_onehot
);

  int w_base;
  int w_best;

  // Rotating-distance search: the winner is the requester closest to the base
  always_comb begin
    w_base   = i_rr ? int'(i_ptr) : 0;
    w_best   = MN;
    o_onehot = '0;
    for (int j = 0; j < MN; j++) begin
      if (i_req[j] && (((j - w_base + MN) % MN) < w_best))
        w_best = (j - w_base + MN) % MN;
    end
    for (int j = 0; j < MN; j++) begin
      o_onehot[j] = i_req[j] && (((j - w_base + MN) % MN) == w_best);
    end
  end

endmodule
`default_nettype wire

// File: rtl/qmem_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : qmem_rr_arbiter
//  Purpose  : N-master to 1-slave QMEM arbiter, fixed or round-robin priority,
//             per-master burst lock, zero-latency grant from idle.
//             Optional request watchdog enabled by defining QMEM_ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module qmem_rr_arbiter
  import qmem_arb_pkg::*;
#(
  parameter int QAW    = 32,
  parameter int QDW    = 32,
  parameter int QSW    = QDW/8,
  parameter int MN     = 4,
  parameter int RR     = 1,
  parameter int TO_CNT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MN-1:0]     qm_cs,
  input  logic [MN-1:0]     qm_we,
  input  logic [MN-1:0]     qm_lock,
  input  logic [MN*QSW-1:0] qm_sel,
  input  logic [MN*QAW-1:0] qm_adr,
  input  logic [MN*QDW-1:0] qm_dat_w,
  output logic [MN*QDW-1:0] qm_dat_r,
  output logic [MN-1:0]     qm_ack,
  output logic [MN-1:0]     qm_err,
  output logic              qs_cs,
  output logic              qs_we,
  output logic [QSW-1:0]    qs_sel,
  output logic [QAW-1:0]    qs_adr,
  output logic [QDW-1:0]    qs_dat_w,
  input  logic [QDW-1:0]    qs_dat_r,
  input  logic              qs_ack,
  input  logic              qs_err,
  output logic [MN-1:0]     ms
);

  localparam int MIDW = midw(MN);
  localparam bit c_rr = (RR == ARB_RR);

  logic [MN-1:0]   r_gnt;
  logic [MIDW-1:0] r_ptr;
  logic [MN-1:0]   w_gnt_nxt;
  logic [MIDW-1:0] w_ptr_nxt;
  logic [MN-1:0]   w_pick;
  logic [MN-1:0]   w_ms;
  logic [MIDW-1:0] w_idx;
  logic [MIDW-1:0] w_idx_inc;
  logic            w_busy;
  logic            w_cmpl;
  logic            w_lock_g;
  logic            w_cs_g;
  logic            w_to;

  qmem_rr_picker #(
    .MN   (MN),
    .MIDW (MIDW)
  ) u_picker (
    .i_req    (qm_cs),
    .i_ptr    (r_ptr),
    .i_rr     (c_rr),
    .o_onehot (w_pick)
  );

  // Current grant: held grant when busy, otherwise the live pick; forced off in reset
  always_comb begin
    w_busy    = (r_gnt != '0);
    w_ms      = rst_n ? (w_busy ? r_gnt : w_pick) : '0;
    w_idx     = '0;
    for (int j = 0; j < MN; j++) begin
      if (w_ms[j]) w_idx = w_idx | MIDW'(j);
    end
    w_idx_inc = (w_idx == MIDW'(MN-1)) ? '0 : w_idx + MIDW'(1);
    w_cmpl    = (qs_ack | qs_err) & (w_ms != '0);
    w_lock_g  = |(qm_lock & w_ms);
    w_cs_g    = |(qm_cs & w_ms);
  end

`ifdef QMEM_ARB_TIMEOUT_EN
  localparam int WDW = (clog2(TO_CNT) > 0) ? clog2(TO_CNT) : 1;
  logic [WDW-1:0] r_wdog;
  logic [WDW-1:0] w_wdog_nxt;

  assign w_to = (w_ms != '0) & ~w_cmpl & (r_wdog == WDW'(TO_CNT-1));

  // Watchdog restarts whenever the grant completes, times out or goes away
  always_comb begin
    w_wdog_nxt = ((w_gnt_nxt == '0) || w_cmpl || w_to) ? '0 : r_wdog + WDW'(1);
  end

  // Watchdog register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wdog <= '0;
    else        r_wdog <= w_wdog_nxt;
  end
`else
  assign w_to = 1'b0;
`endif

  // State register: held grant and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt <= '0;
      r_ptr <= '0;
    end else begin
      r_gnt <= w_gnt_nxt;
      r_ptr <= w_ptr_nxt;
    end
  end

  // Next state: a lock keeps the grant across completion, even a zero-latency one
  always_comb begin
    w_gnt_nxt = r_gnt;
    w_ptr_nxt = r_ptr;
    if (w_to) begin
      w_gnt_nxt = '0;
      if (c_rr) w_ptr_nxt = w_idx_inc;
    end else if (w_cmpl) begin
      w_gnt_nxt = w_lock_g ? w_ms : '0;
      if (c_rr) w_ptr_nxt = w_idx_inc;
    end else if (!w_busy) begin
      w_gnt_nxt = w_pick;
    end else if (!w_lock_g && !w_cs_g) begin
      w_gnt_nxt = '0;
    end
  end

  // Outputs: slave side copies the granted slice, master side gets gated handshakes
  always_comb begin
    qs_we    = qm_we[0];
    qs_sel   = qm_sel[QSW-1:0];
    qs_adr   = qm_adr[QAW-1:0];
    qs_dat_w = qm_dat_w[QDW-1:0];
    for (int j = 0; j < MN; j++) begin
      if (w_idx == MIDW'(j)) begin
        qs_we    = qm_we[j];
        qs_sel   = qm_sel[j*QSW +: QSW];
        qs_adr   = qm_adr[j*QAW +: QAW];
        qs_dat_w = qm_dat_w[j*QDW +: QDW];
      end
    end
    qs_cs    = w_cs_g & ~w_to;
    qm_ack   = w_ms & {MN{qs_ack}};
    qm_err   = w_ms & {MN{qs_err | w_to}};
    qm_dat_r = {MN{qs_dat_r}};
    ms       = w_ms;
  end

endmodule
`default_nettype wire

// File: tb/tb_qmem_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qmem_rr_arbiter
//  Purpose  : Self-checking bench for qmem_rr_arbiter. A fixed-priority and a
//             round-robin instance share stimulus; an integer-level model of
//             grant/pointer/watchdog predicts every output on every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qmem_rr_arbiter;

  localparam int MN  = 4;
  localparam int QAW = 32;
  localparam int QDW = 32;
  localparam int QSW = 4;
  localparam int TO  = 16;
`ifdef QMEM_ARB_TIMEOUT_EN
  localparam bit TOEN = 1'b1;
`else
  localparam bit TOEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [MN-1:0]     qm_cs, qm_we, qm_lock;
  logic [MN*QSW-1:0] qm_sel;
  logic [MN*QAW-1:0] qm_adr;
  logic [MN*QDW-1:0] qm_dat_w;
  logic [QDW-1:0]    qs_dat_r;
  logic              qs_ack, qs_err;

  logic [MN*QDW-1:0] o_dr  [2];
  logic [MN-1:0]     o_ack [2];
  logic [MN-1:0]     o_err [2];
  logic [MN-1:0]     o_ms  [2];
  logic              o_cs  [2];
  logic              o_we  [2];
  logic [QSW-1:0]    o_sel [2];
  logic [QAW-1:0]    o_adr [2];
  logic [QDW-1:0]    o_dw  [2];

  qmem_rr_arbiter #(.QAW(QAW), .QDW(QDW), .QSW(QSW), .MN(MN), .RR(0), .TO_CNT(TO)) u_fx (
    .clk(clk), .rst_n(rst_n), .qm_cs(qm_cs), .qm_we(qm_we), .qm_lock(qm_lock),
    .qm_sel(qm_sel), .qm_adr(qm_adr), .qm_dat_w(qm_dat_w), .qm_dat_r(o_dr[0]),
    .qm_ack(o_ack[0]), .qm_err(o_err[0]), .qs_cs(o_cs[0]), .qs_we(o_we[0]),
    .qs_sel(o_sel[0]), .qs_adr(o_adr[0]), .qs_dat_w(o_dw[0]), .qs_dat_r(qs_dat_r),
    .qs_ack(qs_ack), .qs_err(qs_err), .ms(o_ms[0])
  );

  qmem_rr_arbiter #(.QAW(QAW), .QDW(QDW), .QSW(QSW), .MN(MN), .RR(1), .TO_CNT(TO)) u_rr (
    .clk(clk), .rst_n(rst_n), .qm_cs(qm_cs), .qm_we(qm_we), .qm_lock(qm_lock),
    .qm_sel(qm_sel), .qm_adr(qm_adr), .qm_dat_w(qm_dat_w), .qm_dat_r(o_dr[1]),
    .qm_ack(o_ack[1]), .qm_err(o_err[1]), .qs_cs(o_cs[1]), .qs_we(o_we[1]),
    .qs_sel(o_sel[1]), .qs_adr(o_adr[1]), .qs_dat_w(o_dw[1]), .qs_dat_r(qs_dat_r),
    .qs_ack(qs_ack), .qs_err(qs_err), .ms(o_ms[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model state per instance: granted index (-1 = none held), pointer, watchdog count
  int mg [2] = '{-1, -1};
  int mp [2] = '{0, 0};
  int mw [2] = '{0, 0};

  function automatic bit bitof(input logic [MN-1:0] v, input int i);
    logic [MN-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic int pick(input logic [MN-1:0] cs, input int st);
    for (int i = 0; i < MN; i++) begin
      if (bitof(cs, (st + i) % MN)) return (st + i) % MN;
    end
    return -1;
  endfunction

  task automatic model_cycle(input int m);
    int cur, s;
    bit comp, to;
    logic [MN-1:0] ems;
    string t;
    t   = (m == 0) ? "fx" : "rr";
    cur = -1;
    if (rst_n) cur = (mg[m] >= 0) ? mg[m] : pick(qm_cs, (m == 1) ? mp[m] : 0);
    ems  = (cur >= 0) ? (MN'(1) << cur) : '0;
    s    = (cur >= 0) ? cur : 0;
    comp = (cur >= 0) && (qs_ack || qs_err);
    to   = TOEN && (cur >= 0) && !comp && (mw[m] == TO - 1);
    chk({t, "_ms"},    o_ms[m],  ems);
    chk({t, "_ack"},   o_ack[m], qs_ack ? ems : '0);
    chk({t, "_err"},   o_err[m], (qs_err || to) ? ems : '0);
    chk({t, "_qscs"},  o_cs[m],  (cur >= 0) && bitof(qm_cs, s) && !to);
    chk({t, "_qswe"},  o_we[m],  bitof(qm_we, s));
    chk({t, "_qssel"}, o_sel[m], QSW'(qm_sel >> (s * QSW)));
    chk({t, "_qsadr"}, o_adr[m], QAW'(qm_adr >> (s * QAW)));
    chk({t, "_qsdw"},  o_dw[m],  QDW'(qm_dat_w >> (s * QDW)));
    chk({t, "_datr"},  o_dr[m],  {MN{qs_dat_r}});
    if (!rst_n) begin
      mg[m] = -1; mp[m] = 0; mw[m] = 0;
    end else if (cur < 0) begin
      mw[m] = 0;
    end else if (to) begin
      mg[m] = -1; mw[m] = 0;
      if (m == 1) mp[m] = (cur + 1) % MN;
    end else if (comp) begin
      mg[m] = bitof(qm_lock, cur) ? cur : -1;
      mw[m] = 0;
      if (m == 1) mp[m] = (cur + 1) % MN;
    end else if (mg[m] < 0) begin
      mg[m] = cur; mw[m] = mw[m] + 1;
    end else if (!bitof(qm_lock, cur) && !bitof(qm_cs, cur)) begin
      mg[m] = -1; mw[m] = 0;
    end else begin
      mw[m] = mw[m] + 1;
    end
  endtask

  // Compare both instances against the model once per cycle, mid-period
  always @(negedge clk) begin
    model_cycle(0);
    model_cycle(1);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nxt();
    rst_n = 1'b0; qm_cs = '0; qm_lock = '0; qs_ack = 1'b0; qs_err = 1'b0;
    @(negedge clk);
    nxt();
    rst_n = 1'b1;
  endtask

  logic [MN-1:0] seq [5];

  initial begin
    rst_n = 1'b0; qm_cs = '0; qm_we = '0; qm_lock = '0; qm_sel = '0;
    qm_adr = '0; qm_dat_w = '0; qs_dat_r = '0; qs_ack = 1'b0; qs_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ms",   o_ms[1],  4'b0000);
    chk("rst_qscs", o_cs[1],  1'b0);
    chk("rst_ack",  o_ack[1], 4'b0000);
    nxt();
    rst_n = 1'b1;

    // Fixed priority, masters 1 and 3 request, slave acks on the third cycle
    qm_cs = 4'b1010;
    @(negedge clk); chk("t1_ms0", o_ms[0], 4'b0010);
    nxt();
    @(negedge clk); chk("t1_ms1", o_ms[0], 4'b0010); chk("t1_ack1", o_ack[0], 4'b0000);
    nxt(); qs_ack = 1'b1;
    @(negedge clk); chk("t1_ms2", o_ms[0], 4'b0010); chk("t1_ack2", o_ack[0], 4'b0010);
    nxt(); qs_ack = 1'b0; qm_cs = '0;
    @(negedge clk); chk("t1_ack3", o_ack[0], 4'b0000);

    // Round robin, everyone requesting, every transfer acked immediately
    do_reset();
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    qm_cs = 4'b1111; qs_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); chk($sformatf("t2_ms%0d", k), o_ms[1], seq[k]);
      nxt();
    end

    // Locked burst on master 2, three acks, then release hands over to master 3
    qs_ack = 1'b0; qm_cs = 4'b0100; qm_lock = 4'b0100;
    @(negedge clk); chk("t3_ms_start", o_ms[1], 4'b0100);
    nxt(); qm_cs = 4'b1111; qs_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t3_ms%0d", k), o_ms[1], 4'b0100);
      chk($sformatf("t3_ack%0d", k), o_ack[1], 4'b0100);
      nxt();
    end
    qs_ack = 1'b0; qm_cs = 4'b1011; qm_lock = 4'b0000;
    @(negedge clk); chk("t3_ms_rel", o_ms[1], 4'b0100); chk("t3_qscs_rel", o_cs[1], 1'b0);
    nxt();
    @(negedge clk); chk("t3_ms_next", o_ms[1], 4'b1000);

    // Zero-latency completion from idle leaves no held grant
    do_reset();
    qm_cs = 4'b0001; qs_ack = 1'b1;
    @(negedge clk); chk("t4_ack", o_ack[1], 4'b0001); chk("t4_ms", o_ms[1], 4'b0001);
    nxt(); qm_cs = '0; qs_ack = 1'b0;
    @(negedge clk); chk("t4_ms_after", o_ms[1], 4'b0000);

`ifdef QMEM_ARB_TIMEOUT_EN
    // Slave never answers: watchdog errors out master 1 and passes on to master 3
    do_reset();
    qm_cs = 4'b1010;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 14) chk("t5_err14", o_err[1], 4'b0000);
      if (k == 15) begin
        chk("t5_err15", o_err[1], 4'b0010);
        chk("t5_qscs15", o_cs[1], 1'b0);
      end
      nxt();
    end
    @(negedge clk); chk("t5_ms_next", o_ms[1], 4'b1000);
    nxt(); qm_cs = '0;
`endif

    // Asynchronous reset in the middle of a granted transfer
    do_reset();
    qm_cs = 4'b1111; qs_ack = 1'b1;
    @(negedge clk); nxt();
    @(negedge clk); nxt(); qs_ack = 1'b0;
    @(negedge clk); nxt();
    @(negedge clk); chk("t6_ms_busy", o_ms[1], 4'b0100);
    nxt();
    rst_n = 1'b0; qs_ack = 1'b1;
    #1;
    chk("t6_ms_async", o_ms[1], 4'b0000);
    chk("t6_ack_async", o_ack[1], 4'b0000);
    @(negedge clk);
    nxt(); rst_n = 1'b1; qs_ack = 1'b0;
    @(negedge clk); chk("t6_ms_after", o_ms[1], 4'b0001);

    // Randomised traffic with alternating responsive and sluggish slave phases
    for (int n = 0; n < 3000; n++) begin
      nxt();
      rst_n    = ($urandom_range(0, 399) != 0);
      qm_cs    = MN'($urandom);
      qm_lock  = MN'($urandom & $urandom & $urandom);
      qm_we    = MN'($urandom);
      qm_sel   = (MN*QSW)'($urandom);
      qm_adr   = {$urandom, $urandom, $urandom, $urandom};
      qm_dat_w = {$urandom, $urandom, $urandom, $urandom};
      qs_dat_r = $urandom;
      if (((n / 400) % 2) == 0) qs_ack = ($urandom_range(0, 9) < 3);
      else                      qs_ack = ($urandom_range(0, 99) < 3);
      qs_err   = ($urandom_range(0, 19) == 0);
      @(negedge clk);
    end

    nxt();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
